alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Multi-cycle control FSM that sits between instruction issue and the ALU decoder/datapath. It accepts one instruction at a time through a valid/ready handshake and drives the decoder's OpCode and imm4 inputs. It samples the decoder flag outputs into an architectural flag register and supplies the carry-in for ADC/SUC. It also sequences the register write-back and the memory handshake for LDW/STW/PUSH/POP.

Parameters:
MEM_TIMEOUT, 16, maximum number of MEM-state cycles to wait for MemAck before aborting (range 2..255).
REG_BITS, 3, width of the destination register index.

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
InstrValid  input  1  an instruction is presented.
InstrReady  output  1  the sequencer accepts an instruction this cycle.
InstrOp  input  5  instruction opcode, using the ALU opcode map.
InstrImm4  input  4  shift amount / immediate nibble.
InstrRd  input  REG_BITS  destination register.
OpCode  output  5  registered opcode to the ALU decoder.
imm4  output  4  registered imm4 to the ALU decoder.
Cin  output  1  carry-in to the decoder; always equal to FlagC.
C  input  1  decoder carry flag.
V  input  1  decoder overflow flag.
Z  input  1  decoder zero flag.
N  input  1  ALU result bit 15.
FlagC  output  1  registered carry flag.
FlagV  output  1  registered overflow flag.
FlagZ  output  1  registered zero flag.
FlagN  output  1  registered negative flag.
RegWe  output  1  register-file write enable, one cycle.
RegWaddr  output  REG_BITS  write address.
MemReq  output  1  memory request, held until acknowledged.
MemWrite  output  1  1 = store, 0 = load; valid while MemReq is high.
MemAck  input  1  memory acknowledge.
SpUpdate  output  1  one-cycle stack-pointer update strobe.
SpDir  output  1  1 = decrement (PUSH), 0 = increment (POP).
Done  output  1  one-cycle pulse when an instruction retires.
Illegal  output  1  one-cycle pulse for an unsupported opcode.
MemErr  output  1  one-cycle pulse when a memory access times out.

Behaviour:
- States: IDLE, EXEC, MEM, WB.
- Reset values:
  - state = IDLE.
  - OpCode = 5'b11000 (NOP); imm4 = 0.
  - All flags = 0.
  - RegWe, MemReq, MemWrite, SpUpdate, Done, Illegal, MemErr = 0; RegWaddr = 0.
  - InstrReady = 1 in the first cycle after reset.
- InstrReady = (state == IDLE).
  - Accept when InstrValid & InstrReady.
  - InstrValid is ignored in every other state.
- On accept, register InstrOp into OpCode, InstrImm4 into imm4 and InstrRd into RegWaddr; go to EXEC.
  - Exception: opcode 11001 or 11110 pulses Illegal next cycle, stays in IDLE, and leaves flags and OpCode unchanged.
- EXEC is one cycle; the decoder flags are sampled at its end.
  - Arithmetic (00010, 00011, 00110, 00111, 00100, 00101, 01010, 01011, 01110, 01111, 01100, 01101, 11010): update C, V, Z, N.
  - Logic (10000, 10001, 10011, 10010, 10110, 10111) and shifts (11111, 11101, 11100): update Z and N; C and V are held.
  - LLI/LUI (10101, 10100), memory ops and NOP: flags unchanged.
- EXEC exit:
  - Memory ops go to MEM.
  - CMP (00111), CMPI (01111) and NOP (11000) pulse Done and return to IDLE; no RegWe.
  - All others go to WB.
- WB is one cycle: RegWe = 1 and Done = 1; next state IDLE.
  - ALU ops therefore retire 2 cycles after accept, giving a throughput of one instruction per 3 cycles.
- MEM:
  - MemReq is high from the first MEM cycle until MemAck is sampled high.
  - MemWrite = 1 for STW (01000) and PUSH (01001).
  - PUSH: SpUpdate = 1 and SpDir = 1 in the EXEC cycle, before the store.
  - POP: SpUpdate = 1 and SpDir = 0 in the ack cycle.
  - STW/PUSH: Done pulses in the cycle after the ack cycle, then IDLE.
  - LDW/POP: go to WB after the ack cycle.
- Timeout: a counter tracks MEM cycles. If MEM_TIMEOUT cycles pass without MemAck, pulse MemErr, drop MemReq, return to IDLE, with no RegWe and no Done.
- OpCode holds its value through MEM/WB and returns to 11000 on entry to IDLE.
- Cin = FlagC combinationally from the register. A CMP immediately followed by ADC sees the updated carry in the ADC's EXEC cycle.
- Reset asserted in any state returns everything to reset values at that edge. MemReq is low in the cycle after the edge, and no Done or RegWe is issued for the aborted instruction.
- MemAck outside MEM is ignored.

Test Plan:
- Reset for 2 cycles -> OpCode = 11000, imm4 = 0, InstrReady = 1, all flags 0, all strobes 0.
- ADD (00010), Rd = 3, decoder drives C=1 V=0 Z=0 N=1 in EXEC -> cycle+2: RegWe = 1, RegWaddr = 3, Done = 1; FlagC = 1, FlagN = 1.
- CMP with C=1, then ADC (00100) -> CMP gives Done with no RegWe; during the ADC EXEC cycle Cin = 1 and OpCode = 00100.
- LSR (11101), imm4 = 5, decoder Z=1 with prior FlagC = 1 -> EXEC shows OpCode = 11101 and imm4 = 0101; afterwards FlagZ = 1 and FlagC is still 1.
- PUSH with MemAck 3 cycles after MemReq rises -> SpUpdate/SpDir = 1/1 in EXEC; MemReq high for 4 cycles with MemWrite = 1; Done the cycle after ack. Repeat STW with no ack -> MemErr after 16 MEM cycles, no Done.
- Opcode 11001 -> Illegal pulse, flags and OpCode unchanged. Then LDW with Reset raised mid-MEM -> MemReq = 0 next cycle, no RegWe, InstrReady = 1.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM between instruction issue and the ALU decoder/datapath:
// drives OpCode/imm4, keeps the architectural flags and sequences write-back and memory ops.
module alu_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int REG_BITS    = 3
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                InstrValid,
  output logic                InstrReady,
  input  logic [4:0]          InstrOp,
  input  logic [3:0]          InstrImm4,
  input  logic [REG_BITS-1:0] InstrRd,
  output logic [4:0]          OpCode,
  output logic [3:0]          imm4,
  output logic                Cin,
  input  logic                C,
  input  logic                V,
  input  logic                Z,
  input  logic                N,
  output logic                FlagC,
  output logic                FlagV,
  output logic                FlagZ,
  output logic                FlagN,
  output logic                RegWe,
  output logic [REG_BITS-1:0] RegWaddr,
  output logic                MemReq,
  output logic                MemWrite,
  input  logic                MemAck,
  output logic                SpUpdate,
  output logic                SpDir,
  output logic                Done,
  output logic                Illegal,
  output logic                MemErr
);

  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_ILLA = 5'b11001;
  localparam logic [4:0] OP_ILLB = 5'b11110;
  // Load-side memory opcodes live in the otherwise unused 0000x slots of the map.
  localparam logic [4:0] OP_LDW  = 5'b00000;
  localparam logic [4:0] OP_POP  = 5'b00001;
  localparam logic [4:0] OP_STW  = 5'b01000;
  localparam logic [4:0] OP_PUSH = 5'b01001;
  localparam logic [4:0] OP_CMP  = 5'b00111;
  localparam logic [4:0] OP_CMPI = 5'b01111;
  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

  state_t              state_reg, state_next;
  logic [4:0]          opcode_reg, opcode_next;
  logic [3:0]          imm4_reg, imm4_next;
  logic [REG_BITS-1:0] waddr_reg, waddr_next;
  logic                flag_c_reg, flag_c_next;
  logic                flag_v_reg, flag_v_next;
  logic                flag_z_reg, flag_z_next;
  logic                flag_n_reg, flag_n_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic                done_reg, done_next;
  logic                illegal_reg, illegal_next;
  logic                memerr_reg, memerr_next;

  logic is_arith, is_logic, is_mem, is_store, is_push, is_pop, no_wb;

  always_comb begin
    is_arith = 1'b0;
    is_logic = 1'b0;
    case (opcode_reg)
      5'b00010, 5'b00011, 5'b00110, 5'b00111, 5'b00100, 5'b00101, 5'b01010,
      5'b01011, 5'b01110, 5'b01111, 5'b01100, 5'b01101, 5'b11010: is_arith = 1'b1;
      5'b10000, 5'b10001, 5'b10011, 5'b10010, 5'b10110, 5'b10111,
      5'b11111, 5'b11101, 5'b11100:                               is_logic = 1'b1;
      default: ;
    endcase
  end

  assign is_store = (opcode_reg == OP_STW) || (opcode_reg == OP_PUSH);
  assign is_push  = (opcode_reg == OP_PUSH);
  assign is_pop   = (opcode_reg == OP_POP);
  assign is_mem   = is_store || is_pop || (opcode_reg == OP_LDW);
  assign no_wb    = (opcode_reg == OP_CMP) || (opcode_reg == OP_CMPI) || (opcode_reg == OP_NOP);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg   <= IDLE;
      opcode_reg  <= OP_NOP;
      imm4_reg    <= 4'd0;
      waddr_reg   <= '0;
      flag_c_reg  <= 1'b0;
      flag_v_reg  <= 1'b0;
      flag_z_reg  <= 1'b0;
      flag_n_reg  <= 1'b0;
      cnt_reg     <= 8'd0;
      done_reg    <= 1'b0;
      illegal_reg <= 1'b0;
      memerr_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      opcode_reg  <= opcode_next;
      imm4_reg    <= imm4_next;
      waddr_reg   <= waddr_next;
      flag_c_reg  <= flag_c_next;
      flag_v_reg  <= flag_v_next;
      flag_z_reg  <= flag_z_next;
      flag_n_reg  <= flag_n_next;
      cnt_reg     <= cnt_next;
      done_reg    <= done_next;
      illegal_reg <= illegal_next;
      memerr_reg  <= memerr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    opcode_next  = opcode_reg;
    imm4_next    = imm4_reg;
    waddr_next   = waddr_reg;
    flag_c_next  = flag_c_reg;
    flag_v_next  = flag_v_reg;
    flag_z_next  = flag_z_reg;
    flag_n_next  = flag_n_reg;
    cnt_next     = cnt_reg;
    done_next    = 1'b0;
    illegal_next = 1'b0;
    memerr_next  = 1'b0;
    RegWe        = 1'b0;
    Done         = done_reg;
    MemReq       = 1'b0;
    MemWrite     = 1'b0;
    SpUpdate     = 1'b0;
    SpDir        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (InstrValid) begin
          if (InstrOp == OP_ILLA || InstrOp == OP_ILLB) begin
            illegal_next = 1'b1;
          end else begin
            opcode_next = InstrOp;
            imm4_next   = InstrImm4;
            waddr_next  = InstrRd;
            state_next  = EXEC;
          end
        end
      end
      EXEC: begin
        if (is_arith) begin
          flag_c_next = C;
          flag_v_next = V;
        end
        if (is_arith || is_logic) begin
          flag_z_next = Z;
          flag_n_next = N;
        end
        if (is_push) begin
          SpUpdate = 1'b1;
          SpDir    = 1'b1;
        end
        if (is_mem) begin
          cnt_next   = 8'd0;
          state_next = MEM;
        end else if (no_wb) begin
          Done        = 1'b1;
          opcode_next = OP_NOP;
          state_next  = IDLE;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        MemReq   = 1'b1;
        MemWrite = is_store;
        if (MemAck) begin
          SpUpdate = is_pop;
          if (is_store) begin
            // Store retirement is reported one cycle later, from IDLE.
            done_next   = 1'b1;
            opcode_next = OP_NOP;
            state_next  = IDLE;
          end else begin
            state_next = WB;
          end
        end else if (cnt_reg == CNT_LAST) begin
          memerr_next = 1'b1;
          opcode_next = OP_NOP;
          state_next  = IDLE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      WB: begin
        RegWe       = 1'b1;
        Done        = 1'b1;
        opcode_next = OP_NOP;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign InstrReady = (state_reg == IDLE);
  assign OpCode     = opcode_reg;
  assign imm4       = imm4_reg;
  assign RegWaddr   = waddr_reg;
  assign FlagC      = flag_c_reg;
  assign FlagV      = flag_v_reg;
  assign FlagZ      = flag_z_reg;
  assign FlagN      = flag_n_reg;
  assign Cin        = flag_c_reg;
  assign Illegal    = illegal_reg;
  assign MemErr     = memerr_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: retire/strobe events are scoreboarded, cycle-level
// details (flags, OpCode, memory handshake) are checked inline.
module tb_alu_sequencer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       InstrValid = 1'b0;
  logic       InstrReady;
  logic [4:0] InstrOp = 5'd0;
  logic [3:0] InstrImm4 = 4'd0;
  logic [2:0] InstrRd = 3'd0;
  logic [4:0] OpCode;
  logic [3:0] imm4;
  logic       Cin;
  logic       C = 1'b0, V = 1'b0, Z = 1'b0, N = 1'b0;
  logic       FlagC, FlagV, FlagZ, FlagN;
  logic       RegWe;
  logic [2:0] RegWaddr;
  logic       MemReq, MemWrite;
  logic       MemAck = 1'b0;
  logic       SpUpdate, SpDir, Done, Illegal, MemErr;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       done;
    logic       regwe;
    logic [2:0] waddr;
    logic       illegal;
    logic       memerr;
  } ev_t;

  ev_t sb[$];

  alu_sequencer #(.MEM_TIMEOUT(16), .REG_BITS(3)) dut (
    .Clock(Clock), .Reset(Reset), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .InstrOp(InstrOp), .InstrImm4(InstrImm4), .InstrRd(InstrRd), .OpCode(OpCode),
    .imm4(imm4), .Cin(Cin), .C(C), .V(V), .Z(Z), .N(N), .FlagC(FlagC), .FlagV(FlagV),
    .FlagZ(FlagZ), .FlagN(FlagN), .RegWe(RegWe), .RegWaddr(RegWaddr), .MemReq(MemReq),
    .MemWrite(MemWrite), .MemAck(MemAck), .SpUpdate(SpUpdate), .SpDir(SpDir),
    .Done(Done), .Illegal(Illegal), .MemErr(MemErr)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge Clock);
  endtask

  task automatic expect_ev(input logic d, input logic we, input logic [2:0] wa,
                           input logic il, input logic me);
    ev_t e;
    e.done = d; e.regwe = we; e.waddr = wa; e.illegal = il; e.memerr = me;
    sb.push_back(e);
  endtask

  // Presents one instruction; returns at the negedge of its EXEC cycle.
  task automatic issue(input logic [4:0] op, input logic [3:0] im, input logic [2:0] rd);
    InstrValid = 1'b1; InstrOp = op; InstrImm4 = im; InstrRd = rd;
    step();
    InstrValid = 1'b0;
    $display("issue op=%b imm4=%h rd=%0d", op, im, rd);
  endtask

  task automatic set_dec(input logic c, input logic v, input logic z, input logic n);
    C = c; V = v; Z = z; N = n;
  endtask

  // Scoreboard side: every retire/strobe event must match the next queued expectation.
  initial begin
    ev_t obs, exp;
    forever begin
      @(negedge Clock);
      if (Done || RegWe || Illegal || MemErr) begin
        obs.done = Done; obs.regwe = RegWe; obs.waddr = RegWe ? RegWaddr : 3'd0;
        obs.illegal = Illegal; obs.memerr = MemErr;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $error("FAIL unexpected_event observed=%b expected=none", obs);
        end else begin
          exp = sb.pop_front();
          assert (obs === exp) else begin
            failures++;
            $error("FAIL event observed=%b expected=%b", obs, exp);
          end
          $display("event done=%b regwe=%b waddr=%0d illegal=%b memerr=%b",
                   obs.done, obs.regwe, obs.waddr, obs.illegal, obs.memerr);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step(); step();
    chk("rst_opcode", 8'(OpCode), 8'b11000);
    chk("rst_imm4", 8'(imm4), 8'd0);
    chk("rst_ready", 8'(InstrReady), 8'd1);
    chk("rst_flags", {4'd0, FlagC, FlagV, FlagZ, FlagN}, 8'd0);
    chk("rst_strobes", {1'b0, RegWe, MemReq, MemWrite, SpUpdate, Done, Illegal, MemErr}, 8'd0);
    chk("rst_waddr", 8'(RegWaddr), 8'd0);
    Reset = 1'b0;
    step();

    // ADD, Rd=3: retires two cycles after accept
    expect_ev(1, 1, 3'd3, 0, 0);
    issue(5'b00010, 4'd0, 3'd3);
    set_dec(1, 0, 0, 1);
    chk("add_exec_opcode", 8'(OpCode), 8'b00010);
    chk("add_exec_ready", 8'(InstrReady), 8'd0);
    step();
    chk("add_wb_regwe", 8'(RegWe), 8'd1);
    step();
    chk("add_flags", {4'd0, FlagC, FlagV, FlagZ, FlagN}, 8'b1001);
    chk("add_idle_opcode", 8'(OpCode), 8'b11000);

    // CMP then ADC: carry visible in ADC EXEC
    expect_ev(1, 0, 3'd0, 0, 0);
    issue(5'b00111, 4'd0, 3'd5);
    set_dec(1, 0, 1, 0);
    chk("cmp_done", 8'(Done), 8'd1);
    chk("cmp_regwe", 8'(RegWe), 8'd0);
    step();
    expect_ev(1, 1, 3'd2, 0, 0);
    issue(5'b00100, 4'd0, 3'd2);
    chk("adc_cin", 8'(Cin), 8'd1);
    chk("adc_opcode", 8'(OpCode), 8'b00100);
    set_dec(0, 0, 0, 0);
    step(); step();
    chk("adc_flags", {4'd0, FlagC, FlagV, FlagZ, FlagN}, 8'b0000);

    // LSR: Z/N updated, C/V held
    expect_ev(1, 0, 3'd0, 0, 0);
    issue(5'b01111, 4'd0, 3'd0);
    set_dec(1, 1, 0, 0);
    step();
    expect_ev(1, 1, 3'd4, 0, 0);
    issue(5'b11101, 4'd5, 3'd4);
    set_dec(0, 0, 1, 0);
    chk("lsr_opcode", 8'(OpCode), 8'b11101);
    chk("lsr_imm4", 8'(imm4), 8'b0101);
    step(); step();
    chk("lsr_flags", {4'd0, FlagC, FlagV, FlagZ, FlagN}, 8'b1110);

    // PUSH, ack three cycles after MemReq rises
    expect_ev(1, 0, 3'd0, 0, 0);
    issue(5'b01001, 4'd0, 3'd0);
    set_dec(0, 0, 0, 1);
    chk("push_sp", {6'd0, SpUpdate, SpDir}, 8'b11);
    chk("push_exec_memreq", 8'(MemReq), 8'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("push_memreq_c%0d", i), {6'd0, MemReq, MemWrite}, 8'b11);
      if (i == 4) MemAck = 1'b1;
    end
    step();
    MemAck = 1'b0;
    chk("push_after_ack_memreq", 8'(MemReq), 8'd0);
    chk("push_done", 8'(Done), 8'd1);
    chk("push_flags_held", {4'd0, FlagC, FlagV, FlagZ, FlagN}, 8'b1110);

    // POP: SpUpdate in ack cycle, then write-back
    expect_ev(1, 1, 3'd1, 0, 0);
    issue(5'b00001, 4'd0, 3'd1);
    step();
    chk("pop_memreq", {6'd0, MemReq, MemWrite}, 8'b10);
    MemAck = 1'b1;
    #1;
    chk("pop_sp", {6'd0, SpUpdate, SpDir}, 8'b10);
    step();
    MemAck = 1'b0;
    chk("pop_wb_regwe", 8'(RegWe), 8'd1);
    step();

    // STW with no ack: MemErr after 16 MEM cycles
    expect_ev(0, 0, 3'd0, 0, 1);
    issue(5'b01000, 4'd0, 3'd7);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("stw_memreq_c%0d", i), 8'(MemReq), 8'd1);
    end
    step();
    chk("stw_timeout_memreq", 8'(MemReq), 8'd0);
    chk("stw_memerr", 8'(MemErr), 8'd1);
    chk("stw_no_done", 8'(Done), 8'd0);

    // Illegal opcode
    expect_ev(0, 0, 3'd0, 1, 0);
    InstrValid = 1'b1; InstrOp = 5'b11001; InstrImm4 = 4'd0; InstrRd = 3'd0;
    step();
    InstrValid = 1'b0;
    chk("ill_pulse", 8'(Illegal), 8'd1);
    chk("ill_ready", 8'(InstrReady), 8'd1);
    chk("ill_opcode", 8'(OpCode), 8'b11000);
    chk("ill_flags", {4'd0, FlagC, FlagV, FlagZ, FlagN}, 8'b1110);
    step();
    chk("ill_one_cycle", 8'(Illegal), 8'd0);

    // LDW aborted by reset mid-MEM
    issue(5'b00000, 4'd0, 3'd6);
    step();
    chk("ldw_memreq", {6'd0, MemReq, MemWrite}, 8'b10);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("rst_mid_memreq", 8'(MemReq), 8'd0);
    chk("rst_mid_ready", 8'(InstrReady), 8'd1);
    chk("rst_mid_regwe", 8'(RegWe), 8'd0);
    chk("rst_mid_flags", {4'd0, FlagC, FlagV, FlagZ, FlagN}, 8'd0);

    // MemAck outside MEM is ignored
    MemAck = 1'b1;
    step(); step();
    MemAck = 1'b0;
    chk("stray_ack_memreq", 8'(MemReq), 8'd0);
    chk("stray_ack_ready", 8'(InstrReady), 8'd1);
    step();
    chk("scoreboard_empty", 8'(sb.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
